// File: rtl/alu_logic_ex_stage.sv
// alu_logic_ex_stage: bitwise logic execute stage with a 2-entry result buffer
// and a count of results retired to writeback.
module alu_logic_ex_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic [4:0]       rd_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [4:0]       rd_out,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_nxt;
    logic up;
    logic push, pop;
    logic [WIDTH-1:0] res_new, res1;
    logic zero1;
    logic [4:0] rd1;
    assign res_new = op == 2'b00 ? a & b :
                     op == 2'b01 ? a | b :
                     op == 2'b10 ? a ^ b : ~(a | b);
    // up stays low through reset so in_ready only rises after the first edge
    assign in_ready  = up && state != FULL;
    assign out_valid = state != EMPTY;
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   state_nxt = push ? ONE : EMPTY;
            ONE:     state_nxt = (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
            default: state_nxt = pop ? ONE : FULL;
        endcase
    end
    // head lives in result/zero/rd_out; it is left untouched when the buffer drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            up      <= 1'b0;
            retired <= '0;
            result  <= '0;
            zero    <= 1'b0;
            rd_out  <= '0;
            res1    <= '0;
            zero1   <= 1'b0;
            rd1     <= '0;
        end else begin
            state   <= state_nxt;
            up      <= 1'b1;
            retired <= retired + CNT_W'(pop);
            if (push && (state == EMPTY || pop)) begin
                result <= res_new;
                zero   <= ~|res_new;
                rd_out <= rd_in;
            end else if (pop && state == FULL) begin
                result <= res1;
                zero   <= zero1;
                rd_out <= rd1;
            end
            if (push && state == ONE && !pop) begin
                res1  <= res_new;
                zero1 <= ~|res_new;
                rd1   <= rd_in;
            end
        end
    end
endmodule

// File: tb/tb_alu_logic_ex_stage.sv
// tb_alu_logic_ex_stage: directed vectors against a queue model of the stage,
// checked every cycle plus literal expectations.
module tb_alu_logic_ex_stage;
    logic clk = 0, rst_n = 0;
    logic in_valid = 0, out_ready = 0;
    logic [31:0] a = 0, b = 0;
    logic [1:0] op = 0;
    logic [4:0] rd_in = 0;
    logic in_ready, out_valid, zero;
    logic [31:0] result;
    logic [4:0] rd_out;
    logic [15:0] retired;
    int total = 0, bad = 0;
    bit cmp_on = 0;

    alu_logic_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .rd_in(rd_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .rd_out(rd_out),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // model: entries are {rd, zero, result}
    logic [37:0] q[$];
    logic [37:0] m_last = '0;
    logic [15:0] m_cnt = '0;
    bit m_up = 0;

    function automatic logic [31:0] f(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o);
        case (o)
            2'd0: return x & y;
            2'd1: return x | y;
            2'd2: return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_last = '0;
            m_cnt = '0;
            m_up = 0;
        end else begin
            bit do_push, do_pop;
            logic [31:0] r;
            do_push = in_valid && m_up && q.size() < 2;
            do_pop = q.size() > 0 && out_ready;
            r = f(a, b, op);
            if (do_pop) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (do_push) q.push_back({rd_in, r == 32'd0, r});
            if (q.size() > 0) m_last = q[0];
            m_up = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(m_up && q.size() < 2));
            chk("retired", 32'(retired), 32'(m_cnt));
            chk("result", result, m_last[31:0]);
            chk("zero", 32'(zero), 32'(m_last[32]));
            chk("rd_out", 32'(rd_out), 32'(m_last[37:33]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o, input logic [4:0] r);
        in_valid = 1; a = x; b = y; op = o; rd_in = r;
    endtask

    initial begin
        #12;
        chk("rst in_ready", 32'(in_ready), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst retired", 32'(retired), 0);
        chk("rst result", result, 0);
        cmp_on = 1;
        @(negedge clk);
        rst_n = 1;
        step();
        chk("post rst in_ready", 32'(in_ready), 1);

        // AND with immediate retire
        drive(32'hF0F0_F0F0, 32'hFF00_FF00, 2'b00, 5'd5);
        out_ready = 1;
        step();
        in_valid = 0;
        @(negedge clk);
        chk("and result", result, 32'hF000_F000);
        chk("and zero", 32'(zero), 0);
        chk("and rd", 32'(rd_out), 5);
        chk("and retired0", 32'(retired), 0);
        step();
        chk("and retired1", 32'(retired), 1);

        // NOR all-ones, then XOR equal operands replacing the head
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 5'd1);
        step();
        drive(32'h1234_5678, 32'h1234_5678, 2'b10, 5'd2);
        @(negedge clk);
        chk("nor result", result, 32'h0);
        chk("nor zero", 32'(zero), 1);
        step();
        in_valid = 0;
        @(negedge clk);
        chk("xor zero", 32'(zero), 1);
        chk("xor rd", 32'(rd_out), 2);
        step();

        // back-to-back with writeback stalled
        out_ready = 0;
        drive(32'h1, 32'h2, 2'b01, 5'd3);
        step();
        drive(32'h3, 32'h1, 2'b10, 5'd4);
        step();
        drive(32'h6, 32'h3, 2'b00, 5'd6);
        @(negedge clk);
        chk("full in_ready", 32'(in_ready), 0);
        step();
        in_valid = 0;
        @(negedge clk);
        chk("stall result", result, 32'h3);
        chk("stall rd", 32'(rd_out), 3);
        out_ready = 1;
        step();
        @(negedge clk);
        chk("second result", result, 32'h2);
        chk("second rd", 32'(rd_out), 4);
        step();
        @(negedge clk);
        chk("empty out_valid", 32'(out_valid), 0);
        chk("empty hold", result, 32'h2);

        // FULL with in_valid and pop together: pop only
        out_ready = 0;
        drive(32'hA, 32'h5, 2'b01, 5'd7);
        step();
        drive(32'hC, 32'h4, 2'b00, 5'd8);
        step();
        drive(32'hFF, 32'h0, 2'b01, 5'd9);
        out_ready = 1;
        step();
        in_valid = 0;
        out_ready = 0;
        @(negedge clk);
        chk("pop-only valid", 32'(out_valid), 1);
        chk("pop-only in_ready", 32'(in_ready), 1);
        chk("pop-only rd", 32'(rd_out), 8);
        out_ready = 1;
        step();
        out_ready = 0;

        // counter wrap
        drive(32'h1, 32'h1, 2'b00, 5'd10);
        out_ready = 1;
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) step();
        @(negedge clk);
        chk("retired max", 32'(retired), 32'hFFFF);
        step();
        in_valid = 0;
        @(negedge clk);
        chk("retired wrap", 32'(retired), 0);
        step();
        out_ready = 0;

        // async reset while FULL
        drive(32'h11, 32'h22, 2'b01, 5'd11);
        step();
        drive(32'h33, 32'h44, 2'b01, 5'd12);
        step();
        in_valid = 0;
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("async out_valid", 32'(out_valid), 0);
        chk("async retired", 32'(retired), 0);
        chk("async in_ready", 32'(in_ready), 0);
        chk("async result", result, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("released in_ready", 32'(in_ready), 0);
        step();
        chk("after edge in_ready", 32'(in_ready), 1);
        chk("after edge out_valid", 32'(out_valid), 0);
        out_ready = 1;
        repeat (3) step();
        chk("no stale valid", 32'(out_valid), 0);
        chk("no stale result", result, 0);
        @(negedge clk);
        cmp_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
